// File: rtl/fpu_add_pkg.sv
// Shared types and constants for the FP add issue block.
// Holds the FSM state encoding, the quiet-NaN abort value and the default watchdog limit.
package fpu_add_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT_Z = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] SIGN_MASK   = 32'h8000_0000;
  localparam int          TIMEOUT_DEF = 64;

endpackage

// File: rtl/fpu_add_issue_if.sv
// Request / adder / response signal bundle for fpu_add_issue.
// slave is the issue block's view; master is the pipeline-plus-adder environment.
interface fpu_add_issue_if #(
  parameter int TAG_W = 5
);

  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic             req_sub;
  logic [TAG_W-1:0] req_tag;

  logic [31:0]      fpu_a;
  logic             fpu_a_stb;
  logic [31:0]      fpu_b;
  logic             fpu_b_stb;
  logic [31:0]      fpu_z;
  logic             fpu_z_stb;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;
  logic             busy;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_tag,
    input  fpu_z, fpu_z_stb, rsp_ready,
    output req_ready, fpu_a, fpu_a_stb, fpu_b, fpu_b_stb,
    output rsp_valid, rsp_data, rsp_tag, rsp_timeout, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, req_tag,
    output fpu_z, fpu_z_stb, rsp_ready,
    input  req_ready, fpu_a, fpu_a_stb, fpu_b, fpu_b_stb,
    input  rsp_valid, rsp_data, rsp_tag, rsp_timeout, busy
  );

endinterface

// File: rtl/fpu_add_wdog.sv
// Result watchdog: counts enabled cycles from a clear; expired marks the LIMIT-th enabled cycle.
module fpu_add_wdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = en && (cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/fpu_add_issue.sv
// Issues one FP add to a strobe-driven adder (A then B), waits for Z with a watchdog, holds the response.
// Optional macro FPU_ADD_SUB_EN turns a latched req_sub into a sign flip of B.
module fpu_add_issue
  import fpu_add_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  fpu_add_issue_if.slave io
);

`ifdef FPU_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             z_hit;
  logic             expired;

  logic [31:0]      b_q;
  logic             sub_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      fpu_a_q;
  logic [31:0]      fpu_b_q;
  logic [31:0]      rsp_data_q;
  logic             rsp_to_q;

  assign accept = io.req_valid && (state == IDLE);
  assign z_hit  = io.fpu_z_stb && (state == WAIT_Z);

  fpu_add_wdog #(.LIMIT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != WAIT_Z),
    .en      (state == WAIT_Z),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SEND_A;
      SEND_A:  state_nxt = SEND_B;
      SEND_B:  state_nxt = WAIT_Z;
      WAIT_Z:  if (z_hit || expired) state_nxt = RESP;
      RESP:    if (io.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // fpu_b is loaded on the edge entering SEND_B so it only changes in its own strobe cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      b_q        <= '0;
      sub_q      <= 1'b0;
      tag_q      <= '0;
      fpu_a_q    <= '0;
      fpu_b_q    <= '0;
      rsp_data_q <= '0;
      rsp_to_q   <= 1'b0;
    end else begin
      if (accept) begin
        fpu_a_q <= io.req_a;
        b_q     <= io.req_b;
        sub_q   <= io.req_sub;
        tag_q   <= io.req_tag;
      end
      if (state == SEND_A) begin
        fpu_b_q <= b_q ^ ((sub_q && SUB_EN) ? SIGN_MASK : 32'h0);
      end
      if (z_hit) begin
        rsp_data_q <= io.fpu_z;
        rsp_to_q   <= 1'b0;
      end else if (state == WAIT_Z && expired) begin
        rsp_data_q <= FP_QNAN;
        rsp_to_q   <= 1'b1;
      end
    end
  end

  assign io.req_ready   = (state == IDLE);
  assign io.busy        = (state != IDLE);
  assign io.fpu_a       = fpu_a_q;
  assign io.fpu_a_stb   = (state == SEND_A);
  assign io.fpu_b       = fpu_b_q;
  assign io.fpu_b_stb   = (state == SEND_B);
  assign io.rsp_valid   = (state == RESP);
  assign io.rsp_data    = rsp_data_q;
  assign io.rsp_tag     = tag_q;
  assign io.rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_fpu_add_issue.sv
// Bench for fpu_add_issue: vector table plus random transactions against a latency/value model.
module tb_fpu_add_issue;

  localparam int TMO = 8;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
`ifdef FPU_ADD_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [4:0]  tag;
    logic [31:0] z;
    int          d;      // z strobe offset into WAIT_Z; >= TMO means never
    int          hold;   // RESP cycles with rsp_ready low
    bit          stray;  // z strobe during SEND_B, must be ignored
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fpu_add_issue_if #(.TAG_W(5)) bus ();

  fpu_add_issue #(.TAG_W(5), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag_s);
    chk({tag_s, "_a_stb"}, bus.fpu_a_stb, 0);
    chk({tag_s, "_b_stb"}, bus.fpu_b_stb, 0);
    chk({tag_s, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag_s, "_busy"}, bus.busy, 0);
    chk({tag_s, "_req_ready"}, bus.req_ready, 1);
  endtask

  task automatic run_txn(input vec_t v);
    int          lat;
    logic        exp_to;
    logic [31:0] exp_d;
    logic [31:0] exp_b;
    exp_to = (v.d >= TMO);
    lat    = exp_to ? 3 + TMO : 4 + v.d;
    exp_d  = exp_to ? QNAN : v.z;
    exp_b  = (v.sub && SUB_ON) ? {~v.b[31], v.b[30:0]} : v.b;

    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    bus.req_sub   = v.sub;
    bus.req_tag   = v.tag;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    bus.req_tag   = 5'($urandom);

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      bus.fpu_z_stb = (k == 3 + v.d) || (v.stray && k == 2);
      bus.fpu_z     = (k == 3 + v.d) ? v.z : ~v.z;
      chk("fpu_a_stb", bus.fpu_a_stb, (k == 1));
      chk("fpu_b_stb", bus.fpu_b_stb, (k == 2));
      chk("fpu_a", bus.fpu_a, v.a);
      if (k >= 2) chk("fpu_b", bus.fpu_b, exp_b);
      chk("rsp_valid", bus.rsp_valid, (k == lat));
      chk("busy", bus.busy, 1);
    end

    bus.fpu_z_stb = 1'b0;
    chk("rsp_data", bus.rsp_data, exp_d);
    chk("rsp_tag", bus.rsp_tag, v.tag);
    chk("rsp_timeout", bus.rsp_timeout, exp_to);
    chk("req_ready_resp", bus.req_ready, 0);
    bus.rsp_ready = (v.hold == 0);
    bus.req_valid = (v.hold == 0);

    for (int h = 1; h <= v.hold; h++) begin
      @(negedge clk);
      bus.fpu_z_stb = 1'b1;
      bus.fpu_z     = ~exp_d;
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_rsp_data", bus.rsp_data, exp_d);
      chk("hold_rsp_tag", bus.rsp_tag, v.tag);
      chk("hold_rsp_timeout", bus.rsp_timeout, exp_to);
      chk("hold_req_ready", bus.req_ready, 0);
      bus.rsp_ready = (h == v.hold);
      bus.req_valid = (h == v.hold);
    end

    // Request offered in the release cycle must not be taken.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    bus.fpu_z_stb = 1'b0;
    chk_idle_outputs("release");
  endtask

  vec_t vecs[6];

  initial begin
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = 1'b0;
    bus.req_tag   = '0;
    bus.fpu_z     = '0;
    bus.fpu_z_stb = 1'b0;
    bus.rsp_ready = 1'b0;

    vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd3,  32'h4040_0000, 0,   0, 1'b0};
    vecs[1] = '{32'h3F80_0000, 32'h4000_0000, 1'b1, 5'd9,  32'hBF80_0000, 1,   0, 1'b0};
    vecs[2] = '{32'h4120_0000, 32'h4220_0000, 1'b0, 5'd17, 32'h1234_5678, 99,  0, 1'b1};
    vecs[3] = '{32'hC000_0000, 32'h3F00_0000, 1'b0, 5'd30, 32'hBFC0_0000, 2,   5, 1'b0};
    vecs[4] = '{32'h0000_0001, 32'h8000_0001, 1'b1, 5'd31, 32'h4049_0FDB, TMO - 1, 1, 1'b0};
    vecs[5] = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 5'd1,  32'h7F80_0000, TMO - 2, 0, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fpu_a", bus.fpu_a, 0);
    chk("rst_fpu_b", bus.fpu_b, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_tag", bus.rsp_tag, 0);
    chk("rst_rsp_timeout", bus.rsp_timeout, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_rst");

    foreach (vecs[i]) run_txn(vecs[i]);

    for (int n = 0; n < 20; n++) begin
      vec_t r;
      r.a     = $urandom;
      r.b     = $urandom;
      r.sub   = 1'($urandom_range(0, 1));
      r.tag   = 5'($urandom);
      r.z     = $urandom;
      r.d     = $urandom_range(0, TMO + 2);
      r.hold  = $urandom_range(0, 3);
      r.stray = 1'($urandom_range(0, 1));
      run_txn(r);
    end

    // Reset while waiting for the result.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_a     = 32'h4080_0000;
    bus.req_b     = 32'h40A0_0000;
    bus.req_tag   = 5'd12;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midrst");
    chk("midrst_rsp_timeout", bus.rsp_timeout, 0);
    chk("midrst_fpu_a", bus.fpu_a, 0);
    chk("midrst_rsp_tag", bus.rsp_tag, 0);
    rst = 1'b1;
    run_txn('{32'h4080_0000, 32'h40A0_0000, 1'b0, 5'd12, 32'h4110_0000, 0, 0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fpu_add_issue.md
FPU_ADD_ISSUE -- requirements
Module: fpu_add_issue

Interface
REQ-001 The block SHALL have parameter TAG_W, default 5, giving the width of the destination tag carried with each request.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the maximum WAIT_Z cycles before abort (legal range 2..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the pipeline offers an add operation.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block accepts the offered operation.
REQ-007 The block SHALL have ports req_a and req_b, input, 32 bits each: IEEE-754 single-precision operands.
REQ-008 The block SHALL have port req_sub, input, 1 bit: subtract request (see Configuration).
REQ-009 The block SHALL have port req_tag, input, TAG_W bits: destination tag.
REQ-010 The block SHALL have port fpu_a, output, 32 bits: operand A toward the adder.
REQ-011 The block SHALL have port fpu_a_stb, output, 1 bit: strobe marking fpu_a valid.
REQ-012 The block SHALL have port fpu_b, output, 32 bits: operand B toward the adder.
REQ-013 The block SHALL have port fpu_b_stb, output, 1 bit: strobe marking fpu_b valid.
REQ-014 The block SHALL have port fpu_z, input, 32 bits: result from the adder.
REQ-015 The block SHALL have port fpu_z_stb, input, 1 bit: strobe marking the result valid.
REQ-016 The block SHALL have port rsp_valid, output, 1 bit: a response is available.
REQ-017 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the response.
REQ-018 The block SHALL have port rsp_data, output, 32 bits: the result.
REQ-019 The block SHALL have port rsp_tag, output, TAG_W bits: the tag of the response.
REQ-020 The block SHALL have port rsp_timeout, output, 1 bit: the response was aborted.
REQ-021 The block SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-022 The FSM SHALL have states IDLE, SEND_A, SEND_B, WAIT_Z and RESP.
REQ-023 req_ready SHALL be 1 only in IDLE; a request accepted at cycle T (req_valid & req_ready) SHALL latch req_a, req_b, req_tag and req_sub, and move to SEND_A.
REQ-024 In SEND_A, fpu_a_stb SHALL be 1 for exactly one cycle (T+1) with fpu_a = latched A, then the FSM SHALL move to SEND_B.
REQ-025 In SEND_B, fpu_b_stb SHALL be 1 for exactly one cycle (T+2) with fpu_b = latched B, then the FSM SHALL move to WAIT_Z; the strobes SHALL never be asserted together.
REQ-026 fpu_a and fpu_b SHALL hold their values outside their strobe cycles.
REQ-027 In WAIT_Z, the first cycle with fpu_z_stb=1 SHALL capture fpu_z into rsp_data, clear rsp_timeout and move to RESP.
REQ-028 A fpu_z_stb seen in any state other than WAIT_Z SHALL be ignored.
REQ-029 The WAIT_Z cycle counter SHALL clear on entry; if it reaches TIMEOUT without fpu_z_stb, rsp_data SHALL become 0x7FC00000, rsp_timeout SHALL become 1 and the FSM SHALL move to RESP.
REQ-030 If fpu_z_stb and the timeout occur in the same cycle, the result SHALL win.
REQ-031 In RESP, rsp_valid SHALL be 1 and rsp_data, rsp_tag and rsp_timeout SHALL be stable; on rsp_ready the FSM SHALL return to IDLE, with no new request accepted in that same cycle.
REQ-032 The minimum accept-to-rsp_valid latency SHALL be 4 cycles (fpu_z_stb at T+3 gives rsp_valid at T+4).

Reset
REQ-033 While rst=0 at a clock edge, the state SHALL become IDLE, any in-flight operation SHALL be discarded, and fpu_a_stb, fpu_b_stb, rsp_valid, rsp_timeout and the counter SHALL be 0.
REQ-034 While rst=0 at a clock edge, fpu_a, fpu_b, rsp_data and rsp_tag SHALL be 0, busy SHALL be 0, and req_ready SHALL be 1 on the first cycle after reset releases.

Configuration
REQ-035 With macro FPU_ADD_SUB_EN defined, a latched req_sub=1 SHALL invert bit 31 of B before it is driven on fpu_b.
REQ-036 Without FPU_ADD_SUB_EN, req_sub SHALL be ignored and B SHALL pass unmodified; the port list SHALL be identical either way.

Structure
REQ-037 Package fpu_add_pkg SHALL hold the FSM state enum, the constant FP_QNAN = 0x7FC00000 and the default TIMEOUT constant.
REQ-038 The timeout counter SHALL be sub-module fpu_add_wdog, with inputs clr and en and output expired.

Verification
REQ-039 The bench SHALL check: A=0x3F800000, B=0x40000000, fpu_z=0x40400000 at T+3 -> fpu_a_stb only at T+1, fpu_b_stb only at T+2, rsp_valid at T+4 with rsp_data=0x40400000 and rsp_timeout=0.
REQ-040 The bench SHALL check, with FPU_ADD_SUB_EN defined: req_sub=1, B=0x40000000 -> fpu_b=0xC0000000; with the macro undefined -> fpu_b=0x40000000.
REQ-041 The bench SHALL check: TIMEOUT=8 with no fpu_z_stb -> rsp_valid with rsp_data=0x7FC00000 and rsp_timeout=1.
REQ-042 The bench SHALL check: rsp_ready held 0 for 5 cycles in RESP -> rsp outputs stable, req_ready=0 throughout, and a stray fpu_z_stb is ignored.
REQ-043 The bench SHALL check: rst=0 asserted during WAIT_Z -> IDLE next cycle with all strobes and rsp_valid at 0, and a subsequent request completes normally.
REQ-044 The bench SHALL check: fpu_z_stb in the same cycle as counter expiry -> rsp_data = fpu_z and rsp_timeout=0.
